ysyx_22051468_operand_scoreboard: RTL and testbench

Parametrised register scoreboard between decode and execute in the NPC pipeline. It consumes the per-instruction operand-need flags (rd/rs1/rs2) produced by the existing operand-need decoder. It tracks outstanding writes per architectural register and back-pressures issue on RAW hazards, per-register write-count saturation and a global in-flight limit. Optional same-cycle writeback bypass and a flush path are included.

---
 rtl/ysyx_22051468_operand_scoreboard.sv | 109 ++++++++++
 tb/tb_ysyx_22051468_operand_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051468_operand_scoreboard.sv
// Register scoreboard between decode and execute. It tracks outstanding writes per
// architectural register and holds issue back on RAW hazards and resource limits.
module ysyx_22051468_operand_scoreboard #(
  parameter int unsigned NREG         = 32,
  parameter int unsigned RIDX_W       = 5,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned INF_W        = 3,
  parameter int unsigned BYPASS       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic              iss_rd_need,
  input  logic              iss_rs1_need,
  input  logic              iss_rs2_need,
  input  logic [RIDX_W-1:0] iss_rd,
  input  logic [RIDX_W-1:0] iss_rs1,
  input  logic [RIDX_W-1:0] iss_rs2,
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic              flush,
  output logic [INF_W-1:0]  inflight,
  output logic              stall_raw,
  output logic              stall_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);
  localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);
  localparam logic             BYP_EN  = (BYPASS != 0);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [INF_W-1:0] inflight_q;
  logic [INF_W-1:0] inflight_d;

  logic wb_eff;
  logic trk;
  logic byp1;
  logic byp2;
  logic hz1;
  logic hz2;
  logic full_cnt;
  logic full_inf;
  logic full_cond;
  logic fire_trk;

  // x0 is never a producer, so a writeback naming it retires nothing
  assign wb_eff = wb_valid & (wb_rd != '0);
  assign trk    = iss_rd_need & (iss_rd != '0);

  // A source is free if its only pending write retires this very cycle
  assign byp1 = BYP_EN & wb_valid & (wb_rd == iss_rs1) & (cnt_q[iss_rs1] == CNT_ONE);
  assign byp2 = BYP_EN & wb_valid & (wb_rd == iss_rs2) & (cnt_q[iss_rs2] == CNT_ONE);

  assign hz1 = iss_rs1_need & (iss_rs1 != '0) & (cnt_q[iss_rs1] != '0) & ~byp1;
  assign hz2 = iss_rs2_need & (iss_rs2 != '0) & (cnt_q[iss_rs2] != '0) & ~byp2;

  // A same-cycle retirement frees the slot the new instruction needs
  assign full_cnt  = (cnt_q[iss_rd] == CNT_MAX) & ~(wb_valid & (wb_rd == iss_rd));
  assign full_inf  = (inflight_q == INF_MAX) & ~wb_eff;
  assign full_cond = trk & (full_cnt | full_inf);

  assign iss_ready  = ~flush & ~(hz1 | hz2) & ~full_cond;
  assign stall_raw  = iss_valid & (hz1 | hz2);
  assign stall_full = iss_valid & ~stall_raw & full_cond;
  assign inflight   = inflight_q;

  assign fire_trk = iss_valid & iss_ready & trk;

  always_comb begin
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    if (flush) begin
      for (int unsigned i = 0; i < NREG; i++) cnt_d[i] = '0;
      inflight_d = '0;
    end else begin
      if (fire_trk && !(wb_eff && (wb_rd == iss_rd)))
        cnt_d[iss_rd] = cnt_q[iss_rd] + CNT_ONE;
      // Idle-register writebacks are protocol errors; hold at zero
      if (wb_eff && !(fire_trk && (wb_rd == iss_rd)) && (cnt_q[wb_rd] != '0))
        cnt_d[wb_rd] = cnt_q[wb_rd] - CNT_ONE;
      if (fire_trk && !wb_eff)
        inflight_d = inflight_q + INF_ONE;
      else if (!fire_trk && wb_eff && (inflight_q != '0))
        inflight_d = inflight_q - INF_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
      inflight_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wb_eff)
      assert (cnt_q[wb_rd] != '0)
        else $error("writeback to register x%0d with no pending write", wb_rd);
  end

endmodule

// File: tb/tb_ysyx_22051468_operand_scoreboard.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a counting model and
// queues them; a monitor on the falling edge pops and compares against the DUT.
module tb_ysyx_22051468_operand_scoreboard;

  localparam int NREG    = 32;
  localparam int CNT_MAX = 3;
  localparam int MAXI    = 4;
  localparam int BYP     = 1;

  logic       clk = 1'b0;
  logic       rst, iss_valid, iss_ready, iss_rd_need, iss_rs1_need, iss_rs2_need;
  logic [4:0] iss_rd, iss_rs1, iss_rs2, wb_rd;
  logic       wb_valid, flush, stall_raw, stall_full;
  logic [2:0] inflight;

  ysyx_22051468_operand_scoreboard #(
    .NREG(32), .RIDX_W(5), .CNT_W(2), .MAX_INFLIGHT(4), .INF_W(3), .BYPASS(BYP)
  ) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rd_need(iss_rd_need), .iss_rs1_need(iss_rs1_need), .iss_rs2_need(iss_rs2_need),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .inflight(inflight), .stall_raw(stall_raw), .stall_full(stall_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int  cyc;
    bit  ready;
    bit  raw;
    bit  full;
    int  infl;
  } exp_t;

  exp_t q[$];
  int   pend [NREG];
  int   infl;
  bit   known = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // Abstract model: outstanding writes per register and a running total
  task automatic cyc(input bit v, input bit rdn, input int rd, input bit r1n, input int r1,
                     input bit r2n, input int r2, input bit wbv, input int wbrd,
                     input bit fl, input bit rs);
    exp_t e;
    bit   hz1, hz2, tracked, retires, full, fire;
    @(posedge clk);
    #1;
    cycle++;
    rst = rs; flush = fl; iss_valid = v;
    iss_rd_need = rdn; iss_rs1_need = r1n; iss_rs2_need = r2n;
    iss_rd = 5'(rd); iss_rs1 = 5'(r1); iss_rs2 = 5'(r2);
    wb_valid = wbv; wb_rd = 5'(wbrd);
    if (!known) begin
      if (rs) known = 1'b1;
      return;
    end
    retires = wbv && wbrd != 0;
    hz1 = r1n && r1 != 0 && pend[r1] > 0 && !(BYP != 0 && wbv && wbrd == r1 && pend[r1] == 1);
    hz2 = r2n && r2 != 0 && pend[r2] > 0 && !(BYP != 0 && wbv && wbrd == r2 && pend[r2] == 1);
    tracked = rdn && rd != 0;
    full = tracked && ((pend[rd] >= CNT_MAX && !(wbv && wbrd == rd)) || (infl >= MAXI && !retires));
    e.cyc   = cycle;
    e.ready = !fl && !hz1 && !hz2 && !full;
    e.raw   = v && (hz1 || hz2);
    e.full  = v && !(hz1 || hz2) && full;
    e.infl  = infl;
    q.push_back(e);
    fire = v && e.ready && tracked;
    if (rs || fl) begin
      for (int r = 0; r < NREG; r++) pend[r] = 0;
      infl = 0;
    end else begin
      if (fire) begin pend[rd]++; infl++; end
      if (retires) begin
        if (pend[wbrd] > 0) pend[wbrd]--;
        if (infl > 0) infl--;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue_rd(input int rd);
    cyc(1, 1, rd, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input int r);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, r, 0, 0);
  endtask

  // Monitor: outputs are combinational from state, so mid-cycle is a safe sample point
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 4;
        if (iss_ready !== e.ready) begin
          errors++;
          $display("FAIL ready cyc=%0d got=%b exp=%b", e.cyc, iss_ready, e.ready);
        end
        if (stall_raw !== e.raw) begin
          errors++;
          $display("FAIL stall_raw cyc=%0d got=%b exp=%b", e.cyc, stall_raw, e.raw);
        end
        if (stall_full !== e.full) begin
          errors++;
          $display("FAIL stall_full cyc=%0d got=%b exp=%b", e.cyc, stall_full, e.full);
        end
        if (inflight !== 3'(e.infl)) begin
          errors++;
          $display("FAIL inflight cyc=%0d got=%0d exp=%0d", e.cyc, inflight, e.infl);
        end
      end
    end
  end

  initial begin
    int  cand[$];
    bit  v, rdn, r1n, r2n, wbv, fl, rs;
    int  rd, r1, r2, wbrd;
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    infl = 0;
    rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_rd_need = 1'b0;
    iss_rs1_need = 1'b0; iss_rs2_need = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    wb_valid = 1'b0; wb_rd = '0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // RAW on x5, cleared by a same-cycle writeback through the bypass
    issue_rd(5);
    cyc(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 5, 0, 0, 1, 5, 0, 0);
    idle();

    // x0 as destination and source
    issue_rd(0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // In-flight limit, relieved by a same-cycle writeback
    for (int r = 1; r <= 4; r++) issue_rd(r);
    issue_rd(6);
    cyc(1, 1, 6, 0, 0, 0, 0, 1, 2, 0, 0);
    wb(1); wb(3); wb(4); wb(6);

    // Per-register counter saturation on x7
    for (int k = 0; k < 3; k++) issue_rd(7);
    issue_rd(7);
    cyc(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
    idle();
    wb(7); wb(7); wb(7);

    // Flush with outstanding writes
    issue_rd(3); issue_rd(9);
    cyc(1, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);

    // Unused rs2 pending, then a store-like instruction
    issue_rd(10);
    cyc(1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 11, 1, 12, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Mid-operation reset
    issue_rd(8); issue_rd(8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 8, 1, 8, 0, 0, 0, 0);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      v   = ($urandom_range(0, 9) < 8);
      rdn = ($urandom_range(0, 3) != 0);
      r1n = $urandom_range(0, 1) != 0;
      r2n = $urandom_range(0, 1) != 0;
      rd  = $urandom_range(0, 9);
      r1  = $urandom_range(0, 9);
      r2  = $urandom_range(0, 9);
      cand.delete();
      for (int r = 1; r < NREG; r++) if (pend[r] > 0) cand.push_back(r);
      wbv  = 1'b0;
      wbrd = $urandom_range(0, 31);
      if ($urandom_range(0, 19) == 0) begin
        wbv = 1'b1; wbrd = 0;
      end else if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
        wbv = 1'b1;
        wbrd = cand[$urandom_range(0, cand.size() - 1)];
      end
      fl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 299) == 0);
      cyc(v, rdn, rd, r1n, r1, r2n, r2, wbv, wbrd, fl, rs);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=cycle %0d exp=completion", cycle);
    $fatal(1, "bench time limit");
  end

endmodule
